rename_retire_queue: RTL
========================

Name: rename_retire_queue

Overview:
- In-order retire queue that drives the free-name side of the rename register file.
- Records each physical name as rename allocates it, and tracks completion out of order.
- Releases names strictly in allocation order via NAME_F/FE, one per cycle.
- Sits between the rename/writeback stages and the rename register file's free port.

Parameters:
- name_width, 1: width of a physical register name.
- tag_width, 2: log2 of queue depth.
- depth, 4: number of entries; must equal 2**tag_width.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  synchronous active-low reset.
- ENQ_NAME  input  name_width  physical name just allocated by rename.
- ENQ_E  input  1  enqueue request.
- ENQ_READY  output  1  queue not full; enqueue accepted when ENQ_E && ENQ_READY.
- ENQ_TAG  output  tag_width  slot index the current enqueue will occupy (tail index).
- DONE_TAG  input  tag_width  slot whose instruction completed.
- DONE_E  input  1  completion strobe.
- RETIRE_EN  input  1  downstream permits a free this cycle.
- NAME_F  output  name_width  name of the head entry.
- FE  output  1  free strobe; head is retired this cycle.
- COUNT  output  tag_width+1  number of occupied entries.
- EMPTY  output  1  COUNT == 0.

Behaviour:
- Storage and pointers:
  - Entry array: name[depth], done[depth].
  - head and tail pointers, each tag_width+1 bits with a wrap bit.
  - Slot index = low tag_width bits of the pointer.
- Full/empty:
  - full = (head and tail indices equal) && (wrap bits differ).
  - empty = pointers equal.
  - COUNT = tail - head, modulo 2**(tag_width+1).
- Reset (RST_N low at posedge):
  - head = tail = 0; all done bits = 0.
  - Outputs after reset: FE=0, EMPTY=1, COUNT=0, ENQ_READY=1, ENQ_TAG=0.
  - name[] contents are don't-care.
  - Reset mid-operation discards all entries; no FE is issued for them.
- Enqueue:
  - ENQ_READY = !full (combinational).
  - On accept: name[tail] <= ENQ_NAME, done[tail] <= 0, tail++.
  - ENQ_TAG is combinational from tail, valid in the same cycle as the accept.
- Completion:
  - On DONE_E: done[DONE_TAG] <= 1, applied only if DONE_TAG addresses an occupied slot. Otherwise the strobe is ignored.
  - A completion becomes retire-eligible the cycle after it is written (no same-cycle bypass).
- Retire (combinational):
  - FE = !empty && done[head_idx] && RETIRE_EN.
  - NAME_F = name[head_idx].
  - On FE: done[head_idx] <= 0, head++.
  - At most one retire per cycle.
  - NAME_F is the new name; the register file maps it to its old name internally.
- Simultaneous events:
  - Enqueue and retire in the same cycle: both take effect; COUNT unchanged.
  - When full, ENQ_READY=0 even if FE=1 in that cycle (no pass-through).
  - A DONE_E for the head slot in the same cycle as FE for that slot cannot occur, because the head is already done.
- Wrap-around: pointers wrap naturally at 2**(tag_width+1); slot indices wrap at depth.

Optional Feature:
- Macro: RENAME_RETIRE_QUEUE_FLUSH_EN.
- When defined, adds input FLUSH (1 bit). FLUSH high at a posedge:
  - tail <= head and all done bits are cleared.
  - FE is forced 0 and ENQ_READY is forced 0 that cycle; any enqueue is dropped.
  - Queue is empty from the next cycle.
  - FLUSH has lower priority than reset.
- When not defined: no FLUSH port; entries leave only by retire or reset.

Decomposition:
- Shared package rename_retire_pkg holds:
  - default tag_width/depth constants;
  - the pointer type (tag_width+1 bits);
  - helper functions ptr_idx, ptr_full and ptr_empty.
- One natural sub-module: rrq_wrap_ptr, a wrap-bit pointer register with increment, load and synchronous reset. It is instantiated for head and tail.

Test Plan:
- Reset then idle → EMPTY=1, COUNT=0, FE=0, ENQ_READY=1, ENQ_TAG=0.
- Enqueue names 5,6,7,8 (depth 4) → ENQ_TAG 0,1,2,3; COUNT=4; ENQ_READY=0; a fifth ENQ_E is ignored.
- Complete tags 2,1 then 0 with RETIRE_EN=1:
  - no FE until tag 0 is done;
  - then FE on three consecutive cycles with NAME_F=5,6,7;
  - COUNT ends at 1.
- Full queue; in the cycle the head retires (FE=1), ENQ_E with name 9 → ENQ_READY=0 that cycle, name 9 is rejected; accepted the next cycle at tag 0 (wrap).
- Head done, RETIRE_EN=0 for 3 cycles → FE=0 and head held; RETIRE_EN=1 → single FE with the correct NAME_F.
- RST_N low with 3 entries, 2 of them done → next cycle EMPTY=1 and no FE. With the flush macro defined, FLUSH gives the same result, and a concurrent ENQ_E is dropped.

Source files
------------

// File: rtl/rename_retire_pkg.sv
// Shared types and pointer helpers for the rename retire queue.
package rename_retire_pkg;

  localparam int unsigned TAG_WIDTH = 2;
  localparam int unsigned DEPTH     = 1 << TAG_WIDTH;
  localparam int unsigned PTR_WIDTH = TAG_WIDTH + 1;

  // Pointer carries a wrap bit above the slot index.
  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [TAG_WIDTH-1:0] idx_t;

  // Slot index addressed by a pointer.
  function automatic idx_t ptr_idx(input ptr_t p);
    return p[TAG_WIDTH-1:0];
  endfunction

  // Same slot, different lap: every entry is occupied.
  function automatic logic ptr_full(input ptr_t head, input ptr_t tail);
    return (head[TAG_WIDTH-1:0] == tail[TAG_WIDTH-1:0]) &&
           (head[TAG_WIDTH] != tail[TAG_WIDTH]);
  endfunction

  // Same slot, same lap: nothing held.
  function automatic logic ptr_empty(input ptr_t head, input ptr_t tail);
    return head == tail;
  endfunction

endpackage

// File: rtl/rename_retire_queue_ptr.sv
// Wrap-bit pointer register: synchronous reset, load beats increment.
module rrq_wrap_ptr #(
  parameter int unsigned width = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             inc,
  input  logic             load,
  input  logic [width-1:0] load_val,
  output logic [width-1:0] ptr
);

  // Pointer update; wraps naturally at 2**width.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + width'(1);
    end
  end

endmodule

// File: rtl/rename_retire_queue.sv
// In-order retire queue feeding the rename register file free port.
// Names enter in allocation order, complete out of order, and are freed
// strictly in order, one per cycle.
// Optional: RENAME_RETIRE_QUEUE_FLUSH_EN adds a FLUSH input that empties
// the queue without issuing any frees.
module rename_retire_queue
  import rename_retire_pkg::*;
#(
  parameter int unsigned name_width = 1,
  parameter int unsigned tag_width  = TAG_WIDTH,
  parameter int unsigned depth      = DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
`ifdef RENAME_RETIRE_QUEUE_FLUSH_EN
  input  logic                  FLUSH,
`endif
  input  logic [name_width-1:0] ENQ_NAME,
  input  logic                  ENQ_E,
  output logic                  ENQ_READY,
  output logic [tag_width-1:0]  ENQ_TAG,
  input  logic [tag_width-1:0]  DONE_TAG,
  input  logic                  DONE_E,
  input  logic                  RETIRE_EN,
  output logic [name_width-1:0] NAME_F,
  output logic                  FE,
  output logic [tag_width:0]    COUNT,
  output logic                  EMPTY
);

  ptr_t                  head;
  ptr_t                  tail;
  idx_t                  head_idx;
  idx_t                  tail_idx;
  idx_t                  done_off;
  logic                  full;
  logic                  empty;
  logic                  flush;
  logic                  enq_fire;
  logic                  done_hit;
  logic [name_width-1:0] name_q [depth];
  logic [depth-1:0]      done_q;

`ifdef RENAME_RETIRE_QUEUE_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  // Occupancy, handshakes and the free strobe.
  assign head_idx  = ptr_idx(head);
  assign tail_idx  = ptr_idx(tail);
  assign full      = ptr_full(head, tail);
  assign empty     = ptr_empty(head, tail);
  assign COUNT     = tail - head;
  assign EMPTY     = empty;
  assign ENQ_READY = !full && !flush;
  assign ENQ_TAG   = tail_idx;
  assign enq_fire  = ENQ_E && ENQ_READY;
  assign FE        = !empty && done_q[head_idx] && RETIRE_EN && !flush;
  assign NAME_F    = name_q[head_idx];

  // A completion counts only if its slot lies within [head, tail).
  assign done_off  = idx_t'(DONE_TAG - head_idx);
  assign done_hit  = DONE_E && (ptr_t'(done_off) < COUNT);

  rrq_wrap_ptr #(.width(PTR_WIDTH)) u_head_ptr (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .inc      (FE),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (head)
  );

  // Flush collapses the tail onto the head, dropping every entry.
  rrq_wrap_ptr #(.width(PTR_WIDTH)) u_tail_ptr (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .inc      (enq_fire),
    .load     (flush),
    .load_val (head),
    .ptr      (tail)
  );

  // Name storage; contents are meaningless outside [head, tail).
  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      name_q[tail_idx] <= ENQ_NAME;
    end
  end

  // Completion flags: cleared on allocate and on free, set by writeback.
  always_ff @(posedge CLK) begin
    if (!RST_N || flush) begin
      done_q <= '0;
    end else begin
      if (FE) begin
        done_q[head_idx] <= 1'b0;
      end
      if (enq_fire) begin
        done_q[tail_idx] <= 1'b0;
      end
      if (done_hit) begin
        done_q[DONE_TAG] <= 1'b1;
      end
    end
  end

endmodule
